// File: rtl/apb3_arbiter_master.sv
// Round-robin arbiter sharing one APB3 bus between N_REQ requesters.
// Optional ACCESS timeout abort is built when APB_TIMEOUT_EN is defined.
module apb3_arbiter_master #(
    parameter int N_REQ          = 2,
    parameter int N_BIT_DATA     = 32,
    parameter int N_BIT_ADDRESS  = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                           PCLK,
    input  logic                           PRESET,
    input  logic [N_REQ-1:0]               req_valid,
    input  logic [N_REQ-1:0]               req_write,
    input  logic [N_REQ*N_BIT_ADDRESS-1:0] req_addr,
    input  logic [N_REQ*N_BIT_DATA-1:0]    req_wdata,
    output logic [N_REQ-1:0]               req_ready,
    output logic [N_REQ-1:0]               rsp_valid,
    output logic [N_BIT_DATA-1:0]          rsp_rdata,
    output logic                           rsp_err,
    output logic                           PSEL,
    output logic                           PENABLE,
    output logic                           PWRITE,
    output logic [N_BIT_ADDRESS-1:0]       PADDR,
    output logic [N_BIT_DATA-1:0]          PWDATA,
    input  logic [N_BIT_DATA-1:0]          PRDATA,
    input  logic                           PREADY,
    input  logic                           PSLVERR
);
    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t          state;
    logic [GW-1:0]   last_grant;
    logic [GW-1:0]   nxt;
    logic            any;

`ifdef APB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
`endif

    // Search starts just after the last winner, so the winner drops to lowest priority.
    always_comb begin
        any = 1'b0;
        nxt = last_grant;
        for (int k = 1; k <= N_REQ; k++) begin
            int idx;
            idx = int'(last_grant) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!any && req_valid[idx]) begin
                any = 1'b1;
                nxt = GW'(idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && any && !PRESET) req_ready[nxt] = 1'b1;
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state      <= IDLE;
            last_grant <= GW'(N_REQ - 1);
            PSEL       <= 1'b0;
            PENABLE    <= 1'b0;
            PWRITE     <= 1'b0;
            PADDR      <= '0;
            PWDATA     <= '0;
            rsp_valid  <= '0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
`ifdef APB_TIMEOUT_EN
            cnt        <= '0;
`endif
        end else begin
            rsp_valid <= '0;
            case (state)
                IDLE: begin
                    if (any) begin
                        PWRITE     <= req_write[nxt];
                        PADDR      <= req_addr[nxt*N_BIT_ADDRESS +: N_BIT_ADDRESS];
                        PWDATA     <= req_wdata[nxt*N_BIT_DATA +: N_BIT_DATA];
                        last_grant <= nxt;
                        PSEL       <= 1'b1;
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ACCESS;
`ifdef APB_TIMEOUT_EN
                    cnt     <= '0;
`endif
                end
                ACCESS: begin
                    // last_grant still names the requester that owns this transfer
                    if (PREADY) begin
                        rsp_rdata             <= PWRITE ? '0 : PRDATA;
                        rsp_err               <= PSLVERR;
                        rsp_valid[last_grant] <= 1'b1;
                        PSEL                  <= 1'b0;
                        PENABLE               <= 1'b0;
                        state                 <= IDLE;
                    end
`ifdef APB_TIMEOUT_EN
                    else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        rsp_rdata             <= '0;
                        rsp_err               <= 1'b1;
                        rsp_valid[last_grant] <= 1'b1;
                        PSEL                  <= 1'b0;
                        PENABLE               <= 1'b0;
                        state                 <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb3_arbiter_master.sv
// Directed bench for apb3_arbiter_master: inputs driven and outputs sampled around the falling edge.
module tb_apb3_arbiter_master;
    localparam int N_REQ = 2;
    localparam int DW = 32;
    localparam int AW = 4;

    logic              PCLK = 1'b0;
    logic              PRESET;
    logic [N_REQ-1:0]  req_valid, req_write, req_ready, rsp_valid;
    logic [N_REQ*AW-1:0] req_addr;
    logic [N_REQ*DW-1:0] req_wdata;
    logic [DW-1:0]     rsp_rdata, PWDATA, PRDATA;
    logic              rsp_err, PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
    logic [AW-1:0]     PADDR;

    int checks = 0;
    int errors = 0;

    apb3_arbiter_master #(
        .N_REQ(N_REQ), .N_BIT_DATA(DW), .N_BIT_ADDRESS(AW), .TIMEOUT_CYCLES(4)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    task automatic tick();
        @(negedge PCLK);
    endtask

    task automatic test_reset();
        PRESET = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
        tick(); tick(); #1;
        checks++;
        if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, req_ready, rsp_valid, rsp_rdata, rsp_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs psel=%b pen=%b pw=%b paddr=%h pwdata=%h rdy=%b rv=%b rd=%h err=%b required all zero",
                     PSEL, PENABLE, PWRITE, PADDR, PWDATA, req_ready, rsp_valid, rsp_rdata, rsp_err);
        end
        PRESET = 1'b0;
    endtask

    task automatic test_read();
        tick();
        req_valid = 2'b01; req_write = 2'b00; req_addr = {4'h0, 4'h4};
        PREADY = 1'b1; PRDATA = 32'hDEADBEEF;
        #1; checks++;
        if (req_ready !== 2'b01) begin errors++; $display("FAIL rd_accept ready=%b required 01", req_ready); end
        tick(); req_valid = '0; #1; checks++;
        if ({req_ready, PSEL, PENABLE, PWRITE, PADDR} !== {2'b00, 1'b1, 1'b0, 1'b0, 4'h4}) begin
            errors++; $display("FAIL rd_setup rdy=%b psel=%b pen=%b pw=%b paddr=%h required 00 1 0 0 4",
                               req_ready, PSEL, PENABLE, PWRITE, PADDR);
        end
        tick(); #1; checks++;
        if ({PSEL, PENABLE, rsp_valid} !== {1'b1, 1'b1, 2'b00}) begin
            errors++; $display("FAIL rd_access psel=%b pen=%b rv=%b required 1 1 00", PSEL, PENABLE, rsp_valid);
        end
        tick(); #1; checks++;
        if ({rsp_valid, rsp_rdata, rsp_err, PSEL} !== {2'b01, 32'hDEADBEEF, 1'b0, 1'b0}) begin
            errors++; $display("FAIL rd_rsp rv=%b rd=%h err=%b psel=%b required 01 deadbeef 0 0",
                               rsp_valid, rsp_rdata, rsp_err, PSEL);
        end
        tick(); #1; checks++;
        if ({rsp_valid, rsp_rdata} !== {2'b00, 32'hDEADBEEF}) begin
            errors++; $display("FAIL rd_hold rv=%b rd=%h required 00 deadbeef", rsp_valid, rsp_rdata);
        end
    endtask

    task automatic test_write_wait();
        req_valid = 2'b10; req_write = 2'b10; req_addr = {4'h9, 4'h0};
        req_wdata = {32'h12345678, 32'h0}; PREADY = 1'b0;
        #1; checks++;
        if (req_ready !== 2'b10) begin errors++; $display("FAIL wr_accept ready=%b required 10", req_ready); end
        for (int i = 1; i <= 5; i++) begin
            tick();
            req_valid = '0; req_wdata = '0; req_addr = '0;
            if (i == 5) PREADY = 1'b1;
            #1; checks++;
            if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid} !== {1'b1, (i > 1), 1'b1, 4'h9, 32'h12345678, 2'b00}) begin
                errors++; $display("FAIL wr_stable cyc=%0d psel=%b pen=%b pw=%b paddr=%h pwdata=%h rv=%b required 1 %b 1 9 12345678 00",
                                   i, PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, (i > 1));
            end
        end
        tick(); #1; checks++;
        if ({rsp_valid, rsp_rdata, rsp_err} !== {2'b10, 32'h0, 1'b0}) begin
            errors++; $display("FAIL wr_rsp rv=%b rd=%h err=%b required 10 0 0", rsp_valid, rsp_rdata, rsp_err);
        end
    endtask

    task automatic test_back_to_back();
        int ng = 0, nr = 0, last = 0;
        logic [1:0] exp_g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        tick();
        req_valid = 2'b11; req_write = 2'b00; PREADY = 1'b1; PRDATA = 32'h5;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (cyc > 0) tick();
            if (ng == 4) req_valid = '0;
            #1;
            if (req_ready !== 2'b00) begin
                checks++;
                if (ng >= 4 || req_ready !== exp_g[ng]) begin
                    errors++; $display("FAIL b2b_grant n=%0d ready=%b required %b", ng, req_ready, exp_g[ng % 4]);
                end
                ng++;
            end
            if (rsp_valid !== 2'b00) begin
                if (nr > 0) begin
                    checks++;
                    if (cyc - last != 3) begin
                        errors++; $display("FAIL b2b_spacing n=%0d gap=%0d required 3", nr, cyc - last);
                    end
                end
                last = cyc; nr++;
            end
        end
        checks++;
        if (ng != 4 || nr != 4) begin
            errors++; $display("FAIL b2b_count grants=%0d rsps=%0d required 4 4", ng, nr);
        end
    endtask

    task automatic test_slverr();
        req_valid = 2'b01; req_write = 2'b00; req_addr = {4'h0, 4'h7};
        PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = 32'hA5A50F0F;
        #1; checks++;
        if (req_ready !== 2'b01) begin errors++; $display("FAIL err_accept ready=%b required 01", req_ready); end
        tick(); req_valid = '0; tick(); tick(); #1; checks++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b01, 1'b1, 32'hA5A50F0F}) begin
            errors++; $display("FAIL err_rsp rv=%b err=%b rd=%h required 01 1 a5a50f0f", rsp_valid, rsp_err, rsp_rdata);
        end
        PSLVERR = 1'b0;
    endtask

    task automatic test_reset_mid();
        tick();
        req_valid = 2'b11; req_write = 2'b11; req_addr = {4'h3, 4'h2};
        req_wdata = {32'h11, 32'h22}; PREADY = 1'b0;
        #1; checks++;
        if (req_ready !== 2'b10) begin errors++; $display("FAIL rst_accept ready=%b required 10", req_ready); end
        tick(); req_valid = '0; tick(); #1; checks++;
        if ({PSEL, PENABLE} !== 2'b11) begin
            errors++; $display("FAIL rst_access psel=%b pen=%b required 1 1", PSEL, PENABLE);
        end
        PRESET = 1'b1; PREADY = 1'b1;
        tick(); #1; checks++;
        if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err, req_ready} !== '0) begin
            errors++; $display("FAIL rst_mid psel=%b pen=%b pw=%b paddr=%h rv=%b rd=%h err=%b rdy=%b required all zero",
                               PSEL, PENABLE, PWRITE, PADDR, rsp_valid, rsp_rdata, rsp_err, req_ready);
        end
        PRESET = 1'b0; req_valid = 2'b11;
        #1; checks++;
        if (req_ready !== 2'b01) begin errors++; $display("FAIL rst_priority ready=%b required 01", req_ready); end
        tick(); req_valid = '0; #1; checks++;
        if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rst_no_rsp rv=%b required 00", rsp_valid); end
        tick(); tick(); tick();
    endtask

`ifdef APB_TIMEOUT_EN
    task automatic test_timeout();
        req_valid = 2'b01; req_write = 2'b00; PREADY = 1'b0; PRDATA = 32'hFFFFFFFF;
        tick(); req_valid = '0;
        for (int i = 1; i <= 4; i++) begin
            tick(); #1; checks++;
            if ({PSEL, PENABLE} !== 2'b11) begin
                errors++; $display("FAIL to_wait cyc=%0d psel=%b pen=%b required 1 1", i, PSEL, PENABLE);
            end
        end
        tick(); #1; checks++;
        if ({PSEL, rsp_valid, rsp_err, rsp_rdata} !== {1'b0, 2'b01, 1'b1, 32'h0}) begin
            errors++; $display("FAIL to_abort psel=%b rv=%b err=%b rd=%h required 0 01 1 0",
                               PSEL, rsp_valid, rsp_err, rsp_rdata);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_read();
        test_write_wait();
        test_back_to_back();
        test_slverr();
        test_reset_mid();
`ifdef APB_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
